meas_pred_ctrl: RTL and testbench

Raster-order block scheduler for the measurement-domain predictor. It walks a picture of BLK_N×BLK_N blocks left-to-right, top-to-bottom and drives the predictor's block coordinates (`cor_x`, `cor_y`). It classifies each block's prediction mode, latches the frame quantiser step, and paces measurement vectors from the CS-measurement engine to the residual/entropy stage with a valid/ready handshake. It issues a one-cycle done pulse when the last block of the frame has left its output register.

---
 rtl/meas_pred_ctrl.sv | 144 ++++++++++++++
 tb/tb_meas_pred_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/meas_pred_ctrl.sv
// meas_pred_ctrl: raster-order block scheduler with mode tagging and valid/ready pacing.
// Optional stall counter output enabled by defining MEAS_PRED_STALL_CNT_EN.
module meas_pred_ctrl #(
   parameter int BLK_N     = 4,
   parameter int PIC_WID   = 13,
   parameter int PIC_HT    = 13,
   parameter int QSTEP_WID = 3,
   parameter int CX_WID    = PIC_WID - $clog2(BLK_N),
   parameter int CY_WID    = PIC_HT - $clog2(BLK_N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CX_WID-1:0]    blk_cols,
   input  logic [CY_WID-1:0]    blk_rows,
   input  logic [QSTEP_WID-1:0] qstep_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [CX_WID-1:0]    cor_x,
   output logic [CY_WID-1:0]    cor_y,
   output logic [QSTEP_WID-1:0] qstep,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           out_mode,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
`ifdef MEAS_PRED_STALL_CNT_EN
   ,
   output logic [31:0]          stall_cnt
`endif
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   logic [1:0]           state_q, state_d;
   logic [CX_WID-1:0]    cols_q, cols_d, cx_q, cx_d;
   logic [CY_WID-1:0]    rows_q, rows_d, cy_q, cy_d;
   logic [QSTEP_WID-1:0] qstep_q, qstep_d;
   logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [1:0]           out_mode_q, out_mode_d;
   logic                 done_q, done_d, cfg_err_q, cfg_err_d;
   logic                 hs, ok_start, x_end, blk_last, fin;
   always_comb begin
      in_ready    = state_q == RUN && (!out_valid_q || out_ready);
      hs          = in_valid && in_ready;
      ok_start    = !abort && state_q == IDLE && start && blk_cols != '0 && blk_rows != '0;
      x_end       = cx_q == cols_q - CX_WID'(1);
      blk_last    = x_end && cy_q == rows_q - CY_WID'(1);
      fin         = state_q == DRAIN && out_valid_q && out_ready && out_last_q;
      state_d     = state_q;
      cols_d      = cols_q;
      rows_d      = rows_q;
      qstep_d     = qstep_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      out_valid_d = out_valid_q;
      out_mode_d  = out_mode_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      cfg_err_d   = !abort && state_q == IDLE && start && !ok_start;
      if (abort) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         cx_d        = '0;
         cy_d        = '0;
      end else begin
         if (ok_start) begin
            state_d = RUN;
            cols_d  = blk_cols;
            rows_d  = blk_rows;
            qstep_d = qstep_in;
            cx_d    = '0;
            cy_d    = '0;
         end
         // The tag register can load a new block while its previous one drains.
         if (hs) begin
            out_valid_d = 1'b1;
            out_mode_d  = {cy_q != '0, cx_q != '0};
            out_last_d  = blk_last;
            state_d     = blk_last ? DRAIN : state_q;
            cx_d        = blk_last ? cx_q : x_end ? '0 : cx_q + CX_WID'(1);
            cy_d        = (!blk_last && x_end) ? cy_q + CY_WID'(1) : cy_q;
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (fin) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cols_q      <= '0;
         rows_q      <= '0;
         qstep_q     <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         out_valid_q <= 1'b0;
         out_mode_q  <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cols_q      <= cols_d;
         rows_q      <= rows_d;
         qstep_q     <= qstep_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         out_valid_q <= out_valid_d;
         out_mode_q  <= out_mode_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end
   assign cor_x     = cx_q;
   assign cor_y     = cy_q;
   assign qstep     = qstep_q;
   assign out_valid = out_valid_q;
   assign out_mode  = out_mode_q;
   assign out_last  = out_last_q;
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;
`ifdef MEAS_PRED_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;
   always_comb begin
      stall_d = ok_start ? '0
              : (state_q != IDLE && out_valid_q && !out_ready && stall_q != '1) ? stall_q + 32'd1
              : stall_q;
   end
   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else stall_q <= stall_d;
   end
   assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_meas_pred_ctrl.sv
// tb_meas_pred_ctrl: directed self-checking bench for meas_pred_ctrl.
module tb_meas_pred_ctrl;
   logic        clk = 1'b0;
   logic        rst, start, abort, in_valid, out_ready;
   logic [10:0] blk_cols, blk_rows, cor_x, cor_y;
   logic [2:0]  qstep_in, qstep;
   logic        in_ready, out_valid, out_last, busy, done, cfg_err;
   logic [1:0]  out_mode;
`ifdef MEAS_PRED_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif
   int checks = 0;
   int errors = 0;
   meas_pred_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .blk_cols(blk_cols), .blk_rows(blk_rows), .qstep_in(qstep_in),
      .in_valid(in_valid), .in_ready(in_ready), .cor_x(cor_x), .cor_y(cor_y),
      .qstep(qstep), .out_valid(out_valid), .out_ready(out_ready),
      .out_mode(out_mode), .out_last(out_last), .busy(busy), .done(done),
      .cfg_err(cfg_err)
`ifdef MEAS_PRED_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );
   always #5 clk = ~clk;
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic begin_frame(input int c, input int r, input int q);
      blk_cols = 11'(c);
      blk_rows = 11'(r);
      qstep_in = 3'(q);
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      blk_cols = '0; blk_rows = '0; qstep_in = '0;
      repeat (2) cyc();
      #1;
      checks++; if ({in_ready, out_valid, out_mode, out_last, busy, done, cfg_err} !== 8'd0) begin errors++; $display("FAIL reset flags: got %b exp 00000000", {in_ready, out_valid, out_mode, out_last, busy, done, cfg_err}); end
      checks++; if ({cor_x, cor_y, qstep} !== 25'd0) begin errors++; $display("FAIL reset coord/qstep: got x=%0d y=%0d q=%0d exp 0", cor_x, cor_y, qstep); end
      rst = 1'b0;
      cyc();
   endtask
   task automatic test_frame_3x2();
      logic [1:0] m [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
      in_valid = 1'b1; out_ready = 1'b1;
      begin_frame(3, 2, 5);
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) cyc();
         #1;
         if (c <= 6) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL f32 in_ready c=%0d: got %b exp 1", c, in_ready); end
            checks++; if (cor_x !== 11'((c - 1) % 3) || cor_y !== 11'((c - 1) / 3)) begin errors++; $display("FAIL f32 cor c=%0d: got (%0d,%0d) exp (%0d,%0d)", c, cor_x, cor_y, (c - 1) % 3, (c - 1) / 3); end
         end
         if (c >= 2 && c <= 7) begin
            checks++; if (out_valid !== 1'b1 || out_mode !== m[c-2]) begin errors++; $display("FAIL f32 mode c=%0d: got v=%b m=%0d exp v=1 m=%0d", c, out_valid, out_mode, m[c-2]); end
            checks++; if (out_last !== (c == 7)) begin errors++; $display("FAIL f32 last c=%0d: got %b exp %b", c, out_last, c == 7); end
         end
         checks++; if (done !== (c == 8)) begin errors++; $display("FAIL f32 done c=%0d: got %b exp %b", c, done, c == 8); end
         checks++; if (busy !== (c <= 7)) begin errors++; $display("FAIL f32 busy c=%0d: got %b exp %b", c, busy, c <= 7); end
         checks++; if (qstep !== 3'd5) begin errors++; $display("FAIL f32 qstep c=%0d: got %0d exp 5", c, qstep); end
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL f32 drained: got out_valid=%b exp 0", out_valid); end
   endtask
   task automatic test_single();
      in_valid = 1'b1; out_ready = 1'b1;
      begin_frame(1, 1, 2);
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) cyc();
         #1;
         if (c == 1) begin
            checks++; if (in_ready !== 1'b1 || cor_x !== 11'd0 || cor_y !== 11'd0) begin errors++; $display("FAIL single in: got rdy=%b (%0d,%0d) exp rdy=1 (0,0)", in_ready, cor_x, cor_y); end
         end
         if (c == 2) begin
            checks++; if ({out_valid, out_mode, out_last, in_ready} !== 5'b10010) begin errors++; $display("FAIL single tag: got v=%b m=%0d l=%b rdy=%b exp v=1 m=0 l=1 rdy=0", out_valid, out_mode, out_last, in_ready); end
         end
         checks++; if (done !== (c == 3) || busy !== (c <= 2)) begin errors++; $display("FAIL single done/busy c=%0d: got %b/%b exp %b/%b", c, done, busy, c == 3, c <= 2); end
      end
   endtask
   task automatic test_stall();
      logic [1:0] tbl [12] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3};
      int recv = 0;
      int sent = 0;
      bit seen_done = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      begin_frame(4, 3, 1);
      for (int c = 1; c <= 40 && !seen_done; c++) begin
         if (c > 1) cyc();
         out_ready = !(c >= 4 && c <= 8);
         #1;
         if (in_valid && in_ready) begin
            checks++; if (cor_x !== 11'(sent % 4) || cor_y !== 11'(sent / 4)) begin errors++; $display("FAIL stall cor blk=%0d: got (%0d,%0d) exp (%0d,%0d)", sent, cor_x, cor_y, sent % 4, sent / 4); end
            sent++;
         end
         if (!out_ready) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall in_ready c=%0d: got %b exp 0", c, in_ready); end
         end
         if (out_valid && recv < 12) begin
            checks++; if (out_mode !== tbl[recv] || out_last !== (recv == 11)) begin errors++; $display("FAIL stall tag blk=%0d: got m=%0d l=%b exp m=%0d l=%b", recv, out_mode, out_last, tbl[recv], recv == 11); end
         end
         if (out_valid && out_ready) recv++;
         if (done) seen_done = 1'b1;
      end
      checks++; if (!seen_done) begin errors++; $display("FAIL stall timeout: got no done exp done within 40 cycles"); end
      checks++; if (recv !== 12 || sent !== 12) begin errors++; $display("FAIL stall count: got out=%0d in=%0d exp 12/12", recv, sent); end
`ifdef MEAS_PRED_STALL_CNT_EN
      checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stall_cnt: got %0d exp 5", stall_cnt); end
`endif
   endtask
   task automatic test_abort();
      in_valid = 1'b1; out_ready = 1'b1;
      begin_frame(4, 4, 3);
      repeat (3) cyc();
      #1;
      checks++; if (cor_x !== 11'd3 || cor_y !== 11'd0) begin errors++; $display("FAIL abort pre cor: got (%0d,%0d) exp (3,0)", cor_x, cor_y); end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      #1;
      checks++; if ({busy, out_valid, done, in_ready} !== 4'b0000) begin errors++; $display("FAIL abort flags: got busy=%b v=%b done=%b rdy=%b exp 0", busy, out_valid, done, in_ready); end
      checks++; if (cor_x !== 11'd0 || cor_y !== 11'd0) begin errors++; $display("FAIL abort cor: got (%0d,%0d) exp (0,0)", cor_x, cor_y); end
      for (int c = 0; c < 4; c++) begin
         cyc();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort no done c=%0d: got %b exp 0", c, done); end
      end
      start = 1'b1; abort = 1'b1;
      cyc();
      start = 1'b0; abort = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL abort+start: got busy=%b err=%b exp 0/0", busy, cfg_err); end
      begin_frame(4, 4, 3);
      #1;
      checks++; if (busy !== 1'b1 || cor_x !== 11'd0 || cor_y !== 11'd0) begin errors++; $display("FAIL restart: got busy=%b (%0d,%0d) exp 1 (0,0)", busy, cor_x, cor_y); end
      cyc();
      checks++; if (out_valid !== 1'b1 || out_mode !== 2'd0 || cor_x !== 11'd1) begin errors++; $display("FAIL restart tag: got v=%b m=%0d x=%0d exp 1/0/1", out_valid, out_mode, cor_x); end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
   endtask
   task automatic test_cfg_err();
      blk_cols = 11'd0; blk_rows = 11'd2; start = 1'b1;
      cyc();
      start = 1'b0;
      #1;
      checks++; if ({cfg_err, busy, in_ready} !== 3'b100) begin errors++; $display("FAIL cfg_err cols0: got err=%b busy=%b rdy=%b exp 1/0/0", cfg_err, busy, in_ready); end
      cyc();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err pulse: got %b exp 0", cfg_err); end
      blk_cols = 11'd3; blk_rows = 11'd0; start = 1'b1;
      cyc();
      start = 1'b0;
      #1;
      checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL cfg_err rows0: got err=%b busy=%b exp 1/0", cfg_err, busy); end
      cyc();
   endtask
   task automatic test_ignore();
      in_valid = 1'b1; out_ready = 1'b1;
      begin_frame(2, 2, 3);
      for (int c = 1; c <= 7; c++) begin
         if (c > 1) cyc();
         start = (c == 2 || c == 3);
         blk_cols = 11'd1; blk_rows = 11'd1; qstep_in = 3'd6;
         #1;
         checks++; if (qstep !== 3'd3) begin errors++; $display("FAIL ignore qstep c=%0d: got %0d exp 3", c, qstep); end
         checks++; if (done !== (c == 6)) begin errors++; $display("FAIL ignore done c=%0d: got %b exp %b", c, done, c == 6); end
         if (c == 4 || c == 5) begin
            checks++; if (out_valid !== 1'b1 || out_last !== (c == 5)) begin errors++; $display("FAIL ignore last c=%0d: got v=%b l=%b exp v=1 l=%b", c, out_valid, out_last, c == 5); end
         end
      end
   endtask
   task automatic test_rst_mid();
      in_valid = 1'b1; out_ready = 1'b1;
      begin_frame(4, 4, 7);
      repeat (2) cyc();
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_mid pre: got v=%b busy=%b exp 1/1", out_valid, busy); end
      rst = 1'b1;
      cyc();
      #1;
      checks++; if ({in_ready, out_valid, out_mode, out_last, busy, done, cfg_err} !== 8'd0) begin errors++; $display("FAIL rst_mid flags: got %b exp 00000000", {in_ready, out_valid, out_mode, out_last, busy, done, cfg_err}); end
      checks++; if ({cor_x, cor_y, qstep} !== 25'd0) begin errors++; $display("FAIL rst_mid coord/qstep: got x=%0d y=%0d q=%0d exp 0", cor_x, cor_y, qstep); end
      rst = 1'b0;
      cyc();
   endtask
   initial begin
      test_reset();
      test_frame_3x2();
      test_single();
      test_stall();
      test_abort();
      test_cfg_err();
      test_ignore();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
